// File: rtl/amdc_eddy_current_sched_if.sv
// Signal bundle between the eddy-current sample scheduler and its controller.
// slave = scheduler side, master = controller / testbench side.
interface amdc_eddy_current_sched_if;
  logic        enable;
  logic [1:0]  trig_mask;
  logic        carrier_high;
  logic        carrier_low;
  logic        sw_trig;
  logic        adc_start;
  logic        adc_done;
  logic [17:0] adc_data_x;
  logic [17:0] adc_data_y;
  logic [17:0] data_x;
  logic [17:0] data_y;
  logic        data_valid;
  logic [15:0] sample_cnt;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;
  logic        timeout_err;
  logic        err_clr;

  modport slave (
    input  enable, trig_mask, carrier_high, carrier_low, sw_trig,
    input  adc_done, adc_data_x, adc_data_y, overrun_clr, err_clr,
    output adc_start, data_x, data_y, data_valid, sample_cnt,
    output busy, overrun, timeout_err
  );

  modport master (
    output enable, trig_mask, carrier_high, carrier_low, sw_trig,
    output adc_done, adc_data_x, adc_data_y, overrun_clr, err_clr,
    input  adc_start, data_x, data_y, data_valid, sample_cnt,
    input  busy, overrun, timeout_err
  );
endinterface

// File: rtl/amdc_eddy_current_sched.sv
// Schedules eddy-current sensor conversions on PWM carrier edges or software request.
// Optional conversion watchdog enabled by defining EDDY_SCHED_TIMEOUT_EN.
module amdc_eddy_current_sched #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
  input  logic                          clk,
  input  logic                          rst,
  amdc_eddy_current_sched_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_high_d;
  logic        r_low_d;
  logic        r_done_d;
  logic        r_adc_start;
  logic        r_data_valid;
  logic [17:0] r_data_x;
  logic [17:0] r_data_y;
  logic [15:0] r_sample_cnt;
  logic        r_overrun;
  logic        r_timeout_err;
  logic        w_rise_high;
  logic        w_rise_low;
  logic        w_rise_done;
  logic        w_trig;
  logic        w_busy;
  logic        w_timeout;
  logic        w_err_clr;

  assign w_rise_high = bus.carrier_high & ~r_high_d;
  assign w_rise_low  = bus.carrier_low  & ~r_low_d;
  assign w_rise_done = bus.adc_done     & ~r_done_d;
  assign w_trig      = bus.enable & ((w_rise_high & bus.trig_mask[0]) |
                                     (w_rise_low  & bus.trig_mask[1]) |
                                     bus.sw_trig);
  assign w_busy      = (r_state != S_IDLE);

`ifdef EDDY_SCHED_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= 16'd0;
    end else if (r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end else begin
      r_to_cnt <= 16'd0;
    end
  end

  // A done edge in the final allowed cycle still counts as success.
  assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == (TIMEOUT_CYCLES - 16'd1)) && !w_rise_done;
  assign w_err_clr = bus.err_clr;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign w_timeout        = 1'b0;
  assign w_err_clr        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_high_d <= 1'b0;
      r_low_d  <= 1'b0;
      r_done_d <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_high_d <= bus.carrier_high;
      r_low_d  <= bus.carrier_low;
      r_done_d <= bus.adc_done;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trig) w_next = S_START;
        else        w_next = S_IDLE;
      end
      S_START:   w_next = S_WAIT;
      S_WAIT: begin
        if (w_rise_done)    w_next = S_CAPTURE;
        else if (w_timeout) w_next = S_IDLE;
        else                w_next = S_WAIT;
      end
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with START/CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adc_start   <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_x      <= 18'd0;
      r_data_y      <= 18'd0;
      r_sample_cnt  <= 16'd0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_adc_start  <= (w_next == S_START);
      r_data_valid <= (w_next == S_CAPTURE);
      if (w_next == S_CAPTURE) begin
        r_data_x     <= bus.adc_data_x;
        r_data_y     <= bus.adc_data_y;
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
      if (w_trig && w_busy) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (w_err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign bus.adc_start   = r_adc_start;
  assign bus.data_valid  = r_data_valid;
  assign bus.data_x      = r_data_x;
  assign bus.data_y      = r_data_y;
  assign bus.sample_cnt  = r_sample_cnt;
  assign bus.busy        = w_busy;
  assign bus.overrun     = r_overrun;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_amdc_eddy_current_sched.sv
// Scoreboard bench for amdc_eddy_current_sched: directed stimulus pushes expected
// captures; a negedge monitor pops and compares on every data_valid pulse.
module tb_amdc_eddy_current_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  amdc_eddy_current_sched_if bus_if();

  amdc_eddy_current_sched #(.TIMEOUT_CYCLES(16'd50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [17:0] x;
    logic [17:0] y;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total      = 0;
  int          bad        = 0;
  int          starts     = 0;
  int          exp_starts = 0;
  logic [15:0] cnt_m      = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: counts start pulses, checks every capture against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus_if.adc_start) starts++;
      if (bus_if.data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cap_x",   {46'd0, bus_if.data_x},     {46'd0, e.x});
          chk("cap_y",   {46'd0, bus_if.data_y},     {46'd0, e.y});
          chk("cap_cnt", {48'd0, bus_if.sample_cnt}, {48'd0, e.cnt});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic trig_sw();
    bus_if.sw_trig = 1'b1;
    exp_starts++;
    step(1);
    bus_if.sw_trig = 1'b0;
  endtask

  task automatic done_edge(input logic [17:0] x, input logic [17:0] y);
    bus_if.adc_data_x = x;
    bus_if.adc_data_y = y;
    bus_if.adc_done   = 1'b1;
    cnt_m = cnt_m + 16'd1;
    exp_q.push_back({x, y, cnt_m});
    step(1);
    bus_if.adc_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus_if.enable       = 1'b0;
    bus_if.trig_mask    = 2'b00;
    bus_if.carrier_high = 1'b0;
    bus_if.carrier_low  = 1'b0;
    bus_if.sw_trig      = 1'b0;
    bus_if.adc_done     = 1'b0;
    bus_if.adc_data_x   = 18'd0;
    bus_if.adc_data_y   = 18'd0;
    bus_if.overrun_clr  = 1'b0;
    bus_if.err_clr      = 1'b0;
    step(3);
    chk("reset_outputs", {7'd0, bus_if.adc_start, bus_if.data_valid, bus_if.data_x, bus_if.data_y,
                          bus_if.sample_cnt, bus_if.busy, bus_if.overrun, bus_if.timeout_err}, 64'd0);
    rst = 1'b0;
    step(2);

    // Carrier-high edge with mask 01, done edge carrying x=0x1234
    bus_if.enable       = 1'b1;
    bus_if.trig_mask    = 2'b01;
    bus_if.carrier_high = 1'b1;
    exp_starts++;
    step(1);
    chk("start_next_cycle", {63'd0, bus_if.adc_start}, 64'd1);
    step(1);
    chk("start_one_cycle", {63'd0, bus_if.adc_start}, 64'd0);
    chk("busy_in_wait", {63'd0, bus_if.busy}, 64'd1);
    step(5);
    bus_if.adc_data_x = 18'h01234;
    bus_if.adc_data_y = 18'h2ABCD;
    bus_if.adc_done   = 1'b1;
    cnt_m = 16'd1;
    exp_q.push_back({18'h01234, 18'h2ABCD, 16'd1});
    step(1);
    chk("valid_after_done", {63'd0, bus_if.data_valid}, 64'd1);
    chk("data_x_0x1234", {46'd0, bus_if.data_x}, 64'h1234);
    step(1);
    chk("valid_one_cycle", {63'd0, bus_if.data_valid}, 64'd0);
    chk("idle_after_capture", {63'd0, bus_if.busy}, 64'd0);

    // Simultaneous carrier + sw trigger; stale done level; overrun behaviour
    bus_if.carrier_high = 1'b0;
    step(1);
    bus_if.carrier_high = 1'b1;
    bus_if.sw_trig      = 1'b1;
    exp_starts++;
    step(1);
    bus_if.sw_trig = 1'b0;
    step(4);
    chk("stale_done_ignored", {63'd0, bus_if.busy}, 64'd1);
    bus_if.sw_trig = 1'b1;
    step(1);
    bus_if.sw_trig = 1'b0;
    chk("overrun_set", {63'd0, bus_if.overrun}, 64'd1);
    bus_if.sw_trig     = 1'b1;
    bus_if.overrun_clr = 1'b1;
    step(1);
    bus_if.sw_trig = 1'b0;
    chk("overrun_set_wins", {63'd0, bus_if.overrun}, 64'd1);
    step(1);
    bus_if.overrun_clr = 1'b0;
    chk("overrun_cleared", {63'd0, bus_if.overrun}, 64'd0);
    bus_if.adc_done = 1'b0;
    step(1);
    done_edge(18'h3FFFF, 18'h00001);
    step(1);
    chk("starts_single_pulse", starts, exp_starts);

    // Disabled triggers, then mask 10 rejects carrier_high and accepts carrier_low
    bus_if.enable       = 1'b0;
    bus_if.carrier_high = 1'b0;
    bus_if.carrier_low  = 1'b0;
    step(1);
    bus_if.carrier_high = 1'b1;
    bus_if.carrier_low  = 1'b1;
    bus_if.sw_trig      = 1'b1;
    step(1);
    bus_if.sw_trig = 1'b0;
    step(2);
    chk("disabled_no_start", {63'd0, bus_if.busy}, 64'd0);
    bus_if.enable       = 1'b1;
    bus_if.trig_mask    = 2'b10;
    bus_if.carrier_high = 1'b0;
    step(1);
    bus_if.carrier_high = 1'b1;
    step(3);
    chk("mask10_rejects_high", {63'd0, bus_if.busy}, 64'd0);
    chk("starts_after_masked", starts, exp_starts);
    bus_if.carrier_low = 1'b0;
    step(1);
    bus_if.carrier_low = 1'b1;
    exp_starts++;
    step(1);
    chk("mask10_low_start", {63'd0, bus_if.adc_start}, 64'd1);
    step(1);
    bus_if.enable = 1'b0;
    step(2);
    done_edge(18'h0AAAA, 18'h15555);
    step(1);
    chk("enable_drop_completes", {63'd0, bus_if.busy}, 64'd0);
    bus_if.enable     = 1'b1;
    bus_if.adc_data_x = 18'h00000;
    step(3);
    chk("data_x_holds", {46'd0, bus_if.data_x}, 64'h0AAAA);

    // Long wait with no done, then reset in the middle of WAIT_DONE
    trig_sw();
    step(200);
`ifdef EDDY_SCHED_TIMEOUT_EN
    chk("timeout_err_set", {63'd0, bus_if.timeout_err}, 64'd1);
    chk("timeout_idle", {63'd0, bus_if.busy}, 64'd0);
    chk("timeout_cnt_kept", {48'd0, bus_if.sample_cnt}, {48'd0, cnt_m});
    trig_sw();
    step(2);
`else
    chk("no_timeout_busy", {63'd0, bus_if.busy}, 64'd1);
`endif
    bus_if.sw_trig = 1'b1;
    step(1);
    bus_if.sw_trig = 1'b0;
    chk("overrun_before_rst", {63'd0, bus_if.overrun}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_wait", {7'd0, bus_if.adc_start, bus_if.data_valid, bus_if.data_x, bus_if.data_y,
                         bus_if.sample_cnt, bus_if.busy, bus_if.overrun, bus_if.timeout_err}, 64'd0);
    cnt_m = 16'd0;
    step(2);
    rst = 1'b0;
    step(1);
    trig_sw();
    step(2);
    done_edge(18'h00555, 18'h00AAA);
    step(1);
    chk("restart_cnt", {48'd0, bus_if.sample_cnt}, 64'd1);

    // Counter wrap from 0xFFFF
    force dut.r_sample_cnt = 16'hFFFF;
    #1;
    release dut.r_sample_cnt;
    cnt_m = 16'hFFFF;
    step(1);
    chk("preload_ffff", {48'd0, bus_if.sample_cnt}, 64'hFFFF);
    trig_sw();
    step(2);
    done_edge(18'h2468A, 18'h13579);
    step(1);
    chk("wrap_to_zero", {48'd0, bus_if.sample_cnt}, 64'd0);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    chk("scoreboard_drained", exp_q.size(), 64'd0);
    chk("starts_total", starts, exp_starts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amdc_eddy_current_sched.md
AMDC_EDDY_CURRENT_SCHED -- requirements
Module: amdc_eddy_current_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd4000, max clk cycles to wait for conversion done.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port enable  in  1  level; gates acceptance of all triggers.
REQ-005 SHALL have port trig_mask  in  2  bit0 selects carrier_high edges, bit1 selects carrier_low edges.
REQ-006 SHALL have port carrier_high  in  1  PWM carrier-peak indicator, synchronous to clk.
REQ-007 SHALL have port carrier_low  in  1  PWM carrier-valley indicator, synchronous to clk.
REQ-008 SHALL have port sw_trig  in  1  single-cycle software trigger pulse, not masked by trig_mask.
REQ-009 SHALL have port adc_start  out  1  one-cycle start pulse to the eddy-current SPI master.
REQ-010 SHALL have port adc_done  in  1  SPI master done level.
REQ-011 SHALL have ports adc_data_x, adc_data_y  in  18 each  SPI master result words.
REQ-012 SHALL have ports data_x, data_y  out  18 each  latched results.
REQ-013 SHALL have port data_valid  out  1  one-cycle pulse when data_x/data_y update.
REQ-014 SHALL have port sample_cnt  out  16  count of completed captures.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port overrun  out  1  sticky: trigger arrived while busy.
REQ-017 SHALL have port overrun_clr  in  1  pulse clears overrun.
REQ-018 SHALL have port timeout_err  out  1  sticky: conversion did not finish in time.
REQ-019 SHALL have port err_clr  in  1  pulse clears timeout_err.

Function
REQ-020 SHALL detect rising edges of carrier_high, carrier_low and adc_done by comparison with their previous-cycle registered values.
REQ-021 SHALL form trig = enable & ((rise_high & trig_mask[0]) | (rise_low & trig_mask[1]) | sw_trig); simultaneous sources in one cycle count as one trigger.
REQ-022 SHALL implement states IDLE, START, WAIT_DONE, CAPTURE.
REQ-023 IDLE: on trig go to START; otherwise stay.
REQ-024 START: adc_start=1 for exactly this cycle; go to WAIT_DONE unconditionally; trigger at cycle N yields adc_start high in cycle N+1.
REQ-025 WAIT_DONE: on adc_done rising edge go to CAPTURE; a done level left high from a prior conversion SHALL NOT count as an edge.
REQ-026 CAPTURE: data_x/data_y take adc_data_x/y, data_valid=1, sample_cnt increments; return to IDLE; done edge in cycle M gives data_valid in cycle M+1.
REQ-027 sample_cnt SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-028 trig while busy SHALL be dropped and set overrun; set SHALL win over a same-cycle overrun_clr.
REQ-029 Deasserting enable mid-operation SHALL NOT abort the current conversion; it completes normally.
REQ-030 data_x/data_y SHALL hold value between captures.

Reset
REQ-031 rst SHALL immediately force state IDLE and all outputs and internal registers to 0 (data_x, data_y, sample_cnt, flags, adc_start, edge history), including mid-conversion.

Configuration
REQ-032 Macro EDDY_SCHED_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_DONE; on reaching TIMEOUT_CYCLES, set timeout_err and return to IDLE with no data_valid and sample_cnt unchanged; set wins over same-cycle err_clr.
REQ-033 Macro undefined: no counter, timeout_err tied 0, err_clr ignored, WAIT_DONE waits indefinitely.

Verification
REQ-034 trig_mask=2'b01, carrier_high rises at cycle 10 -> adc_start high only cycle 11; done edge at 100 with x=18'h1234 -> data_x=18'h1234, data_valid cycle 101, sample_cnt=1.
REQ-035 carrier_high and sw_trig in same cycle -> exactly one adc_start pulse; second sw_trig during WAIT_DONE -> overrun=1, no extra adc_start.
REQ-036 enable=0, all triggers pulsed -> no adc_start; trig_mask=2'b10 with carrier_high edge -> no adc_start.
REQ-037 sample_cnt preloaded via 65535 captures, one more -> sample_cnt=0.
REQ-038 EDDY_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50, adc_done held 0 -> timeout_err=1, back in IDLE, no data_valid; without macro stays busy.
REQ-039 rst asserted mid-WAIT_DONE -> all outputs 0 same cycle; after release next trigger restarts normally.
